// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// uart_rx : oversampled UART receiver, mid-bit sampling, held-data handshake
// Revision: 1.0
// ============================================================================
module uart_rx #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic [15:0]             CYCLES_PER_BIT,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    input  logic                    uart_rx_ack,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_overrun,
    output logic                    uart_rx_busy
);

    localparam int unsigned c_bitcnt_max = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int unsigned c_bitcnt_w   = $clog2(c_bitcnt_max + 1);
    localparam logic [c_bitcnt_w-1:0] c_last_data = c_bitcnt_w'(PAYLOAD_BITS - 1);
    localparam logic [c_bitcnt_w-1:0] c_last_stop = c_bitcnt_w'(STOP_BITS - 1);
    localparam logic [c_bitcnt_w-1:0] c_bit_one   = c_bitcnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q;
    logic                    rxs_q;
    logic [15:0]             cnt_q, cnt_d;
    logic [c_bitcnt_w-1:0]   bitcnt_q, bitcnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    stop_bad_q, stop_bad_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    ferr_q, ferr_d;

    logic                    w_mid;
    logic                    w_wrap;
    logic                    w_deliver;
    logic [PAYLOAD_BITS-1:0] w_shift_in;

    assign w_mid  = (cnt_q == (CYCLES_PER_BIT >> 1));
    assign w_wrap = (cnt_q == CYCLES_PER_BIT);

    // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
    generate
        if (PAYLOAD_BITS == 1) begin : g_shift_single
            assign w_shift_in = rxs_q;
        end else begin : g_shift_multi
            assign w_shift_in = {rxs_q, shift_q[PAYLOAD_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            stop_bad_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= uart_rxd;
            rxs_q      <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            stop_bad_q <= stop_bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = w_wrap ? 16'd0 : (cnt_q + 16'd1);
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        stop_bad_d = stop_bad_q;
        ferr_d     = 1'b0;
        w_deliver  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d      = 16'd0;
                bitcnt_d   = '0;
                stop_bad_d = 1'b0;
                if (uart_rx_en && !rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Restarting the count here puts every later wrap at a bit centre.
                if (w_mid) begin
                    cnt_d   = 16'd0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    shift_d = w_shift_in;
                    if (bitcnt_q == c_last_data) begin
                        bitcnt_d = '0;
                        state_d  = S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + c_bit_one;
                    end
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (bitcnt_q == c_last_stop) begin
                        bitcnt_d   = '0;
                        stop_bad_d = 1'b0;
                        if (stop_bad_q || !rxs_q) begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end else begin
                            w_deliver = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        bitcnt_d   = bitcnt_q + c_bit_one;
                        stop_bad_d = stop_bad_q | ~rxs_q;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held break stays here, so it yields a single error pulse.
                cnt_d = 16'd0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!uart_rx_en) begin
            state_d    = S_IDLE;
            cnt_d      = 16'd0;
            bitcnt_d   = '0;
            stop_bad_d = 1'b0;
            ferr_d     = 1'b0;
            w_deliver  = 1'b0;
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (uart_rx_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // An ack landing in the delivery cycle consumes the old word, so no overrun.
        if (w_deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !uart_rx_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_overrun   = overrun_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_uart_rx : directed + randomized frames against a frame-level receive model
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        uart_rxd;
    logic [15:0] cpb;
    logic        uart_rx_en;
    logic        uart_rx_ack;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_frame_err;
    logic        uart_rx_overrun;
    logic        uart_rx_busy;

    int checks   = 0;
    int failures = 0;

    int   cyc            = 0;
    int   ferr_cnt       = 0;
    int   valid_rise_cyc = -1;
    logic prev_valid     = 1'b0;

    // Frame-level expectation of the held outputs
    logic [7:0] exp_data    = 8'h00;
    logic       exp_valid   = 1'b0;
    logic       exp_overrun = 1'b0;

    uart_rx #(
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (uart_rxd),
        .CYCLES_PER_BIT   (cpb),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_ack      (uart_rx_ack),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_overrun  (uart_rx_overrun),
        .uart_rx_busy     (uart_rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_valid <= uart_rx_valid;
        if (uart_rx_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (uart_rx_valid && !prev_valid) valid_rise_cyc <= cyc;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_data"}, 32'(uart_rx_data), 32'(exp_data));
        chk({tag, "_valid"}, 32'(uart_rx_valid), 32'(exp_valid));
        chk({tag, "_overrun"}, 32'(uart_rx_overrun), 32'(exp_overrun));
    endtask

    // TX bit time is a whole number of clk cycles; nbits truncates the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int period, input int nbits);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = bits[i];
            tick(period);
        end
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (exp_valid) exp_overrun = 1'b1;
        exp_valid = 1'b1;
        exp_data  = b;
    endtask

    task automatic do_ack();
        uart_rx_ack = 1'b1;
        tick(1);
        uart_rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
        end
    endtask

    initial begin
        int start_cyc;
        int ferr_base;
        int nominal;
        int period;
        int nbytes;
        logic [7:0] b;
        logic [15:0] cpb_list [3];

        resetn      = 1'b0;
        uart_rxd    = 1'b1;
        uart_rx_en  = 1'b1;
        uart_rx_ack = 1'b0;
        cpb         = 16'd15;
        tick(3);
        check_held("reset");
        chk("reset_ferr", 32'(uart_rx_frame_err), 32'd0);
        chk("reset_busy", 32'(uart_rx_busy), 32'd0);
        resetn = 1'b1;
        tick(2);

        // Basic frame and latency from start edge to valid
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'hA5);
        check_held("a5");
        chk("a5_latency_window",
            32'((valid_rise_cyc - start_cyc >= 150) && (valid_rise_cyc - start_cyc <= 160)), 32'd1);
        chk("a5_busy", 32'(uart_rx_busy), 32'd0);
        chk("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
        do_ack();
        check_held("a5_ack");

        // Short low glitch is rejected
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(48);
        check_held("glitch");
        chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);
        chk("glitch_busy", 32'(uart_rx_busy), 32'd0);

        // Ack with nothing pending does nothing
        do_ack();
        tick(2);
        check_held("idle_ack");

        // Bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0, 16, 10);
        tick(40 * 16);
        chk("break_ferr_cnt", 32'(ferr_cnt), 32'd1);
        chk("break_busy", 32'(uart_rx_busy), 32'd1);
        check_held("break");
        uart_rxd = 1'b1;
        tick(32);
        chk("break_end_busy", 32'(uart_rx_busy), 32'd0);
        chk("break_end_ferr_cnt", 32'(ferr_cnt), 32'd1);
        send_frame(8'h11, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'h11);
        check_held("after_break");
        do_ack();

        // Two frames with no ack in between
        send_frame(8'h01, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'h01);
        send_frame(8'h02, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'h02);
        check_held("overrun");
        do_ack();
        check_held("overrun_ack");

        // Disable mid-frame discards the partial frame
        send_frame(8'h77, 1'b1, 16, 5);
        uart_rx_en = 1'b0;
        tick(1);
        chk("disable_busy", 32'(uart_rx_busy), 32'd0);
        uart_rxd = 1'b1;
        tick(16 * 6);
        uart_rx_en = 1'b1;
        tick(16);
        check_held("disable");
        chk("disable_ferr_cnt", 32'(ferr_cnt), 32'd1);

        // Reset mid-DATA aborts the frame and clears held outputs
        send_frame(8'h33, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'h33);
        check_held("pre_reset");
        ferr_base = ferr_cnt;
        send_frame(8'hC3, 1'b1, 16, 4);
        resetn = 1'b0;
        tick(2);
        resetn      = 1'b1;
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        uart_rxd    = 1'b1;
        tick(32);
        check_held("mid_reset");
        chk("mid_reset_busy", 32'(uart_rx_busy), 32'd0);
        send_frame(8'h5A, 1'b1, 16, 10);
        uart_rxd = 1'b1;
        tick(32);
        model_deliver(8'h5A);
        check_held("post_reset_5a");
        chk("post_reset_ferr_cnt", 32'(ferr_cnt), 32'(ferr_base));
        do_ack();

        // Random bytes across bit rates with +/-3% transmitter period error
        cpb_list[0] = 16'd1;
        cpb_list[1] = 16'd3;
        cpb_list[2] = 16'd867;
        for (int r = 0; r < 3; r++) begin
            cpb     = cpb_list[r];
            nominal = int'(cpb) + 1;
            nbytes  = (cpb > 16'd100) ? 3 : 8;
            tick(4);
            for (int k = 0; k < nbytes; k++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 0)
                    period = int'($rtoi(real'(nominal) * 0.97 + 0.5));
                else
                    period = int'($rtoi(real'(nominal) * 1.03 + 0.5));
                send_frame(b, 1'b1, period, 10);
                uart_rxd = 1'b1;
                tick(2 * nominal + 4);
                model_deliver(b);
                check_held($sformatf("sweep_cpb%0d_k%0d", cpb, k));
                do_ack();
                chk($sformatf("sweep_cpb%0d_k%0d_acked", cpb, k), 32'(uart_rx_valid), 32'(exp_valid));
            end
        end
        chk("sweep_ferr_cnt", 32'(ferr_cnt), 32'(ferr_base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
